// File: rtl/regfile_wb_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_sched_if
// Brief    : Writeback request, scoreboard and RegFile write-port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_sched_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic                alu_valid;
    logic [AW-1:0]       alu_reg;
    logic [DW-1:0]       alu_data;
    logic                alu_ready;
    logic                mem_valid;
    logic [AW-1:0]       mem_reg;
    logic [DW-1:0]       mem_data;
    logic                mem_ready;
    logic                iss_valid;
    logic [AW-1:0]       iss_reg;
    logic [AW-1:0]       chk_reg1;
    logic [AW-1:0]       chk_reg2;
    logic                chk_busy1;
    logic                chk_busy2;
    logic [(1<<AW)-1:0]  busy_mask;
    logic [AW-1:0]       WriteReg;
    logic [DW-1:0]       WriteData;
    logic                RegWrite;
    logic                err_dup;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        output iss_valid, iss_reg, chk_reg1, chk_reg2,
        input  alu_ready, mem_ready, chk_busy1, chk_busy2, busy_mask,
        input  WriteReg, WriteData, RegWrite, err_dup
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        input  iss_valid, iss_reg, chk_reg1, chk_reg2,
        output alu_ready, mem_ready, chk_busy1, chk_busy2, busy_mask,
        output WriteReg, WriteData, RegWrite, err_dup
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_sched
// Brief    : Round-robin ALU/load writeback arbiter with pending-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_sched #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int ALU_FIRST = 1
) (
    input  wire logic         Clk,
    input  wire logic         rst,
    regfile_wb_sched_if.slave bus
);
    localparam int c_NREG = 1 << AW;
    localparam logic [c_NREG-1:0] c_ONE = {{(c_NREG-1){1'b0}}, 1'b1};

    logic              r_lastAlu;
    logic [AW-1:0]     r_writeReg;
    logic [DW-1:0]     r_writeData;
    logic              r_regWrite;
    logic [c_NREG-1:0] r_busy;
    logic              r_errDup;

    logic              w_grantAlu;
    logic              w_grantMem;
    logic              w_aluXfer;
    logic              w_memXfer;
    logic              w_xfer;
    logic [AW-1:0]     w_xferReg;
    logic [DW-1:0]     w_xferData;
    logic [c_NREG-1:0] w_setMask;
    logic [c_NREG-1:0] w_clrMask;
    logic              w_errXfer;
    logic              w_errIss;

    // A tie goes to whichever side was not served last.
    assign w_grantAlu = bus.alu_valid && (!bus.mem_valid || !r_lastAlu);
    assign w_grantMem = bus.mem_valid && (!bus.alu_valid ||  r_lastAlu);
    assign w_aluXfer  = rst && w_grantAlu;
    assign w_memXfer  = rst && w_grantMem;
    assign w_xfer     = w_aluXfer || w_memXfer;
    assign w_xferReg  = w_aluXfer ? bus.alu_reg  : bus.mem_reg;
    assign w_xferData = w_aluXfer ? bus.alu_data : bus.mem_data;

    assign w_setMask  = bus.iss_valid ? (c_ONE << bus.iss_reg)    : '0;
    assign w_clrMask  = r_regWrite    ? (c_ONE << r_writeReg)     : '0;

    assign w_errXfer  = w_xfer && !r_busy[w_xferReg] && !w_setMask[w_xferReg];
    assign w_errIss   = bus.iss_valid && r_busy[bus.iss_reg] && !w_clrMask[bus.iss_reg];

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            r_lastAlu   <= (ALU_FIRST == 0);
            r_writeReg  <= '0;
            r_writeData <= '0;
            r_regWrite  <= 1'b0;
            r_busy      <= '0;
            r_errDup    <= 1'b0;
        end else begin
            r_regWrite <= w_xfer;
            if (w_xfer) begin
                r_lastAlu   <= w_aluXfer;
                r_writeReg  <= w_xferReg;
                r_writeData <= w_xferData;
            end
            // Set after clear so a fresh issue survives a commit to the same register.
            r_busy   <= (r_busy & ~w_clrMask) | w_setMask;
            r_errDup <= w_errXfer || w_errIss;
        end
    end

    assign bus.alu_ready = w_aluXfer;
    assign bus.mem_ready = w_memXfer;
    assign bus.chk_busy1 = r_busy[bus.chk_reg1];
    assign bus.chk_busy2 = r_busy[bus.chk_reg2];
    assign bus.busy_mask = r_busy;
    assign bus.WriteReg  = r_writeReg;
    assign bus.WriteData = r_writeData;
    assign bus.RegWrite  = r_regWrite;
    assign bus.err_dup   = r_errDup;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_sched
// Brief    : Directed self-checking bench for regfile_wb_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_sched;
    logic Clk;
    logic rst;
    int   nTests = 0;
    int   nFail  = 0;

    regfile_wb_sched_if #(.DW(32), .AW(5)) bus ();

    regfile_wb_sched #(.DW(32), .AW(5), .ALU_FIRST(1)) dut (
        .Clk (Clk),
        .rst (rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every step lands 1 time unit after a rising edge, far from the next one.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd1; bus.alu_data = 32'h11;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd2; bus.mem_data = 32'h22;
        bus.iss_valid = 1'b0; bus.iss_reg = 5'd0;
        bus.chk_reg1  = 5'd0; bus.chk_reg2 = 5'd0;
        repeat (3) tick();

        // Reset values
        chk("rst_alu_ready", bus.alu_ready, 1'b0);
        chk("rst_mem_ready", bus.mem_ready, 1'b0);
        chk("rst_RegWrite",  bus.RegWrite,  1'b0);
        chk("rst_WriteReg",  bus.WriteReg,  5'd0);
        chk("rst_WriteData", bus.WriteData, 32'h0);
        chk("rst_busy_mask", bus.busy_mask, 32'h0);
        chk("rst_err_dup",   bus.err_dup,   1'b0);

        rst = 1'b1;
        #1;
        chk("first_tie_alu", bus.alu_ready, 1'b1);
        chk("first_tie_mem", bus.mem_ready, 1'b0);
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;

        // Single ALU write to r1
        bus.iss_valid = 1'b1; bus.iss_reg = 5'd1;
        tick();
        bus.iss_valid = 1'b0;
        chk("sw_busy_set", bus.busy_mask, 32'h2);
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd1; bus.alu_data = 32'd5;
        #1;
        chk("sw_alu_ready", bus.alu_ready, 1'b1);
        chk("sw_mem_ready", bus.mem_ready, 1'b0);
        tick();
        bus.alu_valid = 1'b0;
        chk("sw_RegWrite",  bus.RegWrite,  1'b1);
        chk("sw_WriteReg",  bus.WriteReg,  5'd1);
        chk("sw_WriteData", bus.WriteData, 32'd5);
        chk("sw_busy_hold", bus.busy_mask, 32'h2);
        chk("sw_err",       bus.err_dup,   1'b0);
        tick();
        chk("sw_RegWrite_off", bus.RegWrite,  1'b0);
        chk("sw_busy_clr",     bus.busy_mask, 32'h0);
        chk("sw_WriteReg_hold",  bus.WriteReg,  5'd1);
        chk("sw_WriteData_hold", bus.WriteData, 32'd5);
        chk("sw_err2",         bus.err_dup,   1'b0);

        // Stall window on r7 through a MEM load
        bus.iss_valid = 1'b1; bus.iss_reg = 5'd7;
        tick();
        bus.iss_valid = 1'b0;
        bus.chk_reg1 = 5'd7; bus.chk_reg2 = 5'd1;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd7; bus.mem_data = 32'hDEADBEEF;
        #1;
        chk("sb_chk1_busy", bus.chk_busy1, 1'b1);
        chk("sb_chk2_idle", bus.chk_busy2, 1'b0);
        chk("sb_mem_ready", bus.mem_ready, 1'b1);
        tick();
        bus.mem_valid = 1'b0;
        chk("sb_RegWrite",  bus.RegWrite,  1'b1);
        chk("sb_WriteReg",  bus.WriteReg,  5'd7);
        chk("sb_WriteData", bus.WriteData, 32'hDEADBEEF);
        chk("sb_chk1_still", bus.chk_busy1, 1'b1);
        tick();
        chk("sb_chk1_clear", bus.chk_busy1, 1'b0);
        chk("sb_err",        bus.err_dup,   1'b0);

        // Re-issue r7 on the edge at which r7 commits
        bus.iss_valid = 1'b1; bus.iss_reg = 5'd7;
        tick();
        bus.iss_valid = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd7; bus.mem_data = 32'h77;
        tick();
        bus.mem_valid = 1'b0;
        chk("ssc_RegWrite", bus.RegWrite, 1'b1);
        bus.iss_valid = 1'b1; bus.iss_reg = 5'd7;
        tick();
        bus.iss_valid = 1'b0;
        chk("ssc_busy7", bus.busy_mask, 32'h80);
        chk("ssc_err",   bus.err_dup,   1'b0);

        // Contention: last served was MEM, so ALU leads
        for (int r = 2; r <= 5; r++) begin
            bus.iss_valid = 1'b1; bus.iss_reg = 5'(r);
            tick();
        end
        bus.iss_valid = 1'b0;
        chk("ct_busy_set", bus.busy_mask, 32'hBC);
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd2; bus.alu_data = 32'hA2;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd3; bus.mem_data = 32'hB3;
        #1;
        chk("ct_alu_first", bus.alu_ready, 1'b1);
        chk("ct_mem_wait",  bus.mem_ready, 1'b0);
        tick();
        bus.alu_reg = 5'd4; bus.alu_data = 32'hA4;
        chk("ct_w1_reg",  bus.WriteReg,  5'd2);
        chk("ct_w1_data", bus.WriteData, 32'hA2);
        chk("ct_w1_busy", bus.busy_mask, 32'hBC);
        #1;
        chk("ct_mem_turn", bus.mem_ready, 1'b1);
        chk("ct_alu_wait", bus.alu_ready, 1'b0);
        tick();
        bus.mem_reg = 5'd5; bus.mem_data = 32'hB5;
        chk("ct_w2_reg",  bus.WriteReg,  5'd3);
        chk("ct_w2_data", bus.WriteData, 32'hB3);
        chk("ct_w2_busy", bus.busy_mask, 32'hB8);
        tick();
        bus.alu_valid = 1'b0;
        chk("ct_w3_reg",  bus.WriteReg,  5'd4);
        chk("ct_w3_data", bus.WriteData, 32'hA4);
        chk("ct_w3_busy", bus.busy_mask, 32'hB0);
        tick();
        bus.mem_valid = 1'b0;
        chk("ct_w4_we",   bus.RegWrite,  1'b1);
        chk("ct_w4_reg",  bus.WriteReg,  5'd5);
        chk("ct_w4_data", bus.WriteData, 32'hB5);
        chk("ct_w4_busy", bus.busy_mask, 32'hA0);
        tick();
        chk("ct_done_we",   bus.RegWrite,  1'b0);
        chk("ct_done_busy", bus.busy_mask, 32'h80);
        chk("ct_err",       bus.err_dup,   1'b0);

        // Write to a never-issued register
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd9; bus.alu_data = 32'h99;
        tick();
        bus.alu_valid = 1'b0;
        chk("er_xfer_pulse", bus.err_dup,  1'b1);
        chk("er_xfer_reg",   bus.WriteReg, 5'd9);
        tick();
        chk("er_xfer_end",   bus.err_dup,   1'b0);
        chk("er_busy",       bus.busy_mask, 32'h80);

        // Issue to a register that is already pending
        bus.iss_valid = 1'b1; bus.iss_reg = 5'd7;
        tick();
        bus.iss_valid = 1'b0;
        chk("er_iss_pulse", bus.err_dup, 1'b1);
        tick();
        chk("er_iss_end",   bus.err_dup, 1'b0);

        // Reset during an ALU transfer to r6
        bus.iss_valid = 1'b1; bus.iss_reg = 5'd6;
        tick();
        bus.iss_valid = 1'b0;
        chk("mr_busy_set", bus.busy_mask, 32'hC0);
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd6; bus.alu_data = 32'h66;
        #1;
        chk("mr_alu_ready", bus.alu_ready, 1'b1);
        rst = 1'b0;
        #1;
        chk("mr_ready_drop", bus.alu_ready, 1'b0);
        chk("mr_busy_async", bus.busy_mask, 32'h0);
        tick();
        chk("mr_no_write", bus.RegWrite, 1'b0);
        bus.alu_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mr_we_after",   bus.RegWrite,  1'b0);
        chk("mr_busy_after", bus.busy_mask, 32'h0);
        chk("mr_reg_after",  bus.WriteReg,  5'd0);
        chk("mr_data_after", bus.WriteData, 32'h0);
        chk("mr_err_after",  bus.err_dup,   1'b0);
        bus.alu_valid = 1'b1; bus.mem_valid = 1'b1;
        #1;
        chk("mr_tie_alu", bus.alu_ready, 1'b1);
        chk("mr_tie_mem", bus.mem_ready, 1'b0);
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
`default_nettype wire
